// File: rtl/vol_cal_seq_pkg.sv
// ---------------------------------------------------------------------------
// vol_cal_seq_pkg
// Shared constants for the volume-side LC DPLL calibration sequencer:
// default widths, the averaging depth, the dither shift forced while
// calibrating, and the rbus control/status register layout.
// ---------------------------------------------------------------------------
package vol_cal_seq_pkg;

  // Datapath widths used by the volume DPLL.
  localparam int VC_DATA_W    = 32;
  localparam int VC_D_SHL_W   = 4;

  // Calibration defaults.
  localparam int VC_SETTLE_W  = 16;
  localparam int VC_AVG_SHR   = 4;   // log2 of samples averaged (1..8)
  localparam int VC_CAL_D_SHL = 0;   // dither shift while calibrating

  // rbus control/status register: start/abort are write pulses,
  // busy/done are read-only status.
  localparam logic [15:0] VC_CTRL_ADDR  = 16'h0040;
  localparam int          VC_CTRL_START = 0;
  localparam int          VC_CTRL_ABORT = 1;
  localparam int          VC_STAT_BUSY  = 2;
  localparam int          VC_STAT_DONE  = 3;

endpackage : vol_cal_seq_pkg

// File: rtl/vol_cal_seq.sv
// ---------------------------------------------------------------------------
// vol_cal_seq
// Calibration sequencer for the volume-side LC DPLL. A start request forces
// the dither shift to a calibration value, waits settle_i+1 clocks, averages
// 2^AVG_SHR strobed LPF samples into a null offset and then hands the dither
// shift back to the user setting. Outside calibration it presents the
// offset-corrected, zero-clamped LPF value to the rbus read path.
//
// Ports:
//   clk_i, rst_n_i   DPLL clock, asynchronous active-low reset
//   cal_start_i      calibration request pulse (ignored while busy)
//   cal_abort_i      abort pulse (wins over start, samples and completion)
//   settle_i         settle wait in clocks, sampled at start
//   d_shl_i/d_shl_o  user dither shift in / dither shift to lc_dpll
//   lpf_i, lpf_vld_i LPF sample and its one-cycle latch strobe
//   busy_o           calibration in progress
//   done_o           one-cycle pulse when ofs_o has been updated
//   ofs_o            current null offset
//   cal_o            max(lpf_i - ofs_o, 0), registered on idle strobes
// ---------------------------------------------------------------------------
module vol_cal_seq
  import vol_cal_seq_pkg::*;
#(
  parameter int DATA_W    = VC_DATA_W,
  parameter int D_SHL_W   = VC_D_SHL_W,
  parameter int SETTLE_W  = VC_SETTLE_W,
  parameter int AVG_SHR   = VC_AVG_SHR,
  parameter int CAL_D_SHL = VC_CAL_D_SHL
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                cal_start_i,
  input  logic                cal_abort_i,
  input  logic [SETTLE_W-1:0] settle_i,
  input  logic [D_SHL_W-1:0]  d_shl_i,
  output logic [D_SHL_W-1:0]  d_shl_o,
  input  logic [DATA_W-1:0]   lpf_i,
  input  logic                lpf_vld_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [DATA_W-1:0]   ofs_o,
  output logic [DATA_W-1:0]   cal_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_ACCUM,
    ST_DONE
  } state_e;

  // Accumulator is wide enough for 2^AVG_SHR full-scale samples.
  localparam int                     ACC_W    = DATA_W + AVG_SHR;
  localparam logic [AVG_SHR-1:0]     SMP_LAST = '1;
  localparam logic [D_SHL_W-1:0]     CAL_SHL  = D_SHL_W'(CAL_D_SHL);

  state_e              state_q, state_d;
  logic [SETTLE_W-1:0] cnt_q,   cnt_d;
  logic [ACC_W-1:0]    acc_q,   acc_d;
  logic [AVG_SHR-1:0]  smp_q,   smp_d;
  logic [DATA_W-1:0]   ofs_q,   ofs_d;
  logic [DATA_W-1:0]   cal_q,   cal_d;
  logic                done_q,  done_d;
  logic [D_SHL_W-1:0]  d_shl_q, d_shl_d;

  // NOTE: every variable gets a default before the case statement so no
  // path leaves one unassigned; that is what keeps this block latch-free.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    smp_d   = smp_q;
    ofs_d   = ofs_q;
    cal_d   = cal_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // Run mode: corrected output, clamped at zero.
        if (lpf_vld_i) begin
          cal_d = (lpf_i > ofs_q) ? (lpf_i - ofs_q) : '0;
        end
        // Abort arriving with start cancels the request.
        if (cal_start_i && !cal_abort_i) begin
          cnt_d   = settle_i;
          acc_d   = '0;
          smp_d   = '0;
          state_d = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        // Strobes are ignored while the loop settles.
        if (cal_abort_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_ACCUM;
        end else begin
          cnt_d = cnt_q - SETTLE_W'(1);
        end
      end

      ST_ACCUM: begin
        if (cal_abort_i) begin
          state_d = ST_IDLE;
        end else if (lpf_vld_i) begin
          acc_d = acc_q + ACC_W'(lpf_i);
          smp_d = smp_q + AVG_SHR'(1);
          if (smp_q == SMP_LAST) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        // An abort here discards the result and leaves ofs_q untouched.
        if (cal_abort_i) begin
          state_d = ST_IDLE;
        end else begin
          ofs_d   = DATA_W'(acc_q >> AVG_SHR);
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // Keyed off the next state so the forced shift appears together with
    // busy_o, and the user value (including any change made meanwhile)
    // returns together with the first idle cycle.
    d_shl_d = (state_d == ST_IDLE) ? d_shl_i : CAL_SHL;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      smp_q   <= '0;
      ofs_q   <= '0;
      cal_q   <= '0;
      done_q  <= 1'b0;
      d_shl_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      smp_q   <= smp_d;
      ofs_q   <= ofs_d;
      cal_q   <= cal_d;
      done_q  <= done_d;
      d_shl_q <= d_shl_d;
    end
  end

  assign busy_o  = (state_q != ST_IDLE);
  assign done_o  = done_q;
  assign ofs_o   = ofs_q;
  assign cal_o   = cal_q;
  assign d_shl_o = d_shl_q;

endmodule : vol_cal_seq

// File: tb/tb_vol_cal_seq.sv
// ---------------------------------------------------------------------------
// tb_vol_cal_seq
// Bench for vol_cal_seq. Two instances share all inputs: dut_a averages
// 4 samples (AVG_SHR=2), dut_b averages 16 (AVG_SHR=4). Expected offsets and
// corrected values come from plain arithmetic on the samples driven.
// ---------------------------------------------------------------------------
module tb_vol_cal_seq;

  localparam int DATA_W   = 32;
  localparam int D_SHL_W  = 4;
  localparam int SETTLE_W = 16;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                cal_start;
  logic                cal_abort;
  logic [SETTLE_W-1:0] settle;
  logic [D_SHL_W-1:0]  d_shl;
  logic [DATA_W-1:0]   lpf;
  logic                lpf_vld;

  logic [D_SHL_W-1:0]  d_shl_a, d_shl_b;
  logic                busy_a, busy_b, done_a, done_b;
  logic [DATA_W-1:0]   ofs_a, ofs_b, cal_a, cal_b;

  int n_cmp = 0;
  int n_err = 0;
  int done_a_cnt = 0;
  int done_b_cnt = 0;

  // Model state: offset and corrected value dut_a should be holding.
  logic [DATA_W-1:0] ofs_m = '0;
  logic [DATA_W-1:0] cal_m = '0;

  always #5 clk = ~clk;

  vol_cal_seq #(.DATA_W(DATA_W), .D_SHL_W(D_SHL_W), .SETTLE_W(SETTLE_W),
                .AVG_SHR(2), .CAL_D_SHL(0)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .cal_start_i(cal_start),
    .cal_abort_i(cal_abort), .settle_i(settle), .d_shl_i(d_shl),
    .d_shl_o(d_shl_a), .lpf_i(lpf), .lpf_vld_i(lpf_vld), .busy_o(busy_a),
    .done_o(done_a), .ofs_o(ofs_a), .cal_o(cal_a));

  vol_cal_seq #(.DATA_W(DATA_W), .D_SHL_W(D_SHL_W), .SETTLE_W(SETTLE_W),
                .AVG_SHR(4), .CAL_D_SHL(0)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .cal_start_i(cal_start),
    .cal_abort_i(cal_abort), .settle_i(settle), .d_shl_i(d_shl),
    .d_shl_o(d_shl_b), .lpf_i(lpf), .lpf_vld_i(lpf_vld), .busy_o(busy_b),
    .done_o(done_b), .ofs_o(ofs_b), .cal_o(cal_b));

  // ---------------- reference model ----------------
  function automatic logic [DATA_W-1:0] sat_sub(input logic [DATA_W-1:0] v,
                                                input logic [DATA_W-1:0] o);
    longint d;
    d = longint'(v) - longint'(o);
    return (d < 0) ? '0 : DATA_W'(d);
  endfunction

  function automatic logic [DATA_W-1:0] mean4(input logic [DATA_W-1:0] s[4]);
    longint sum = 0;
    for (int i = 0; i < 4; i++) sum += longint'(s[i]);
    return DATA_W'(sum / 4);
  endfunction

  // ---------------- stimulus helpers ----------------
  // Advance one clock and sample 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
    if (done_a === 1'b1) done_a_cnt++;
    if (done_b === 1'b1) done_b_cnt++;
  endtask

  task automatic start_cal(input int s);
    settle    = SETTLE_W'(s);
    cal_start = 1'b1;
    step();
    cal_start = 1'b0;
  endtask

  task automatic feed(input logic [DATA_W-1:0] v);
    lpf     = v;
    lpf_vld = 1'b1;
    step();
    lpf_vld = 1'b0;
  endtask

  task automatic wait_idle_a(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      ok = (busy_a === 1'b0);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy_a); end
    n_cmp++; if (done_a !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done_a); end
    n_cmp++; if (ofs_a !== '0) begin n_err++; $display("FAIL reset_ofs: got %0d want 0", ofs_a); end
    n_cmp++; if (cal_a !== '0) begin n_err++; $display("FAIL reset_cal: got %0d want 0", cal_a); end
    rst_n = 1'b1;
    d_shl = 4'd3;
    step();
    n_cmp++; if (d_shl_a !== 4'd3) begin n_err++; $display("FAIL reset_dshl_track: got %0d want 3", d_shl_a); end
  endtask

  task automatic test_settle_gating();
    logic [DATA_W-1:0] s[4];
    logic [DATA_W-1:0] exp;
    bit ok;
    for (int i = 0; i < 4; i++) s[i] = $urandom();
    exp = mean4(s);
    done_a_cnt = 0;
    start_cal(3);
    n_cmp++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL settle_busy: got %b want 1", busy_a); end
    repeat (3) step();
    feed(DATA_W'(9999));               // last SETTLE edge: must be dropped
    for (int i = 0; i < 4; i++) feed(s[i]); // first ACCUM edge onward
    wait_idle_a(4, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL settle_timeout: busy=%b want 0", busy_a); end
    n_cmp++; if (done_a_cnt != 1) begin n_err++; $display("FAIL settle_done_cnt: got %0d want 1", done_a_cnt); end
    n_cmp++; if (ofs_a !== exp) begin n_err++; $display("FAIL settle_ofs: got %0d want %0d", ofs_a, exp); end
    ofs_m = exp;
  endtask

  task automatic test_basic_cal();
    bit ok;
    d_shl = 4'd7;
    step();
    done_a_cnt = 0;
    start_cal(3);
    n_cmp++; if (d_shl_a !== 4'd0) begin n_err++; $display("FAIL basic_dshl_cal: got %0d want 0", d_shl_a); end
    n_cmp++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL basic_busy: got %b want 1", busy_a); end
    repeat (4) step();
    feed(DATA_W'(100)); feed(DATA_W'(102)); feed(DATA_W'(104)); feed(DATA_W'(106));
    wait_idle_a(4, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL basic_timeout: busy=%b want 0", busy_a); end
    n_cmp++; if (done_a !== 1'b1) begin n_err++; $display("FAIL basic_done_with_idle: got %b want 1", done_a); end
    n_cmp++; if (ofs_a !== DATA_W'(103)) begin n_err++; $display("FAIL basic_ofs: got %0d want 103", ofs_a); end
    n_cmp++; if (d_shl_a !== 4'd7) begin n_err++; $display("FAIL basic_dshl_restore: got %0d want 7", d_shl_a); end
    repeat (2) step();
    n_cmp++; if (done_a_cnt != 1) begin n_err++; $display("FAIL basic_done_cnt: got %0d want 1", done_a_cnt); end
    ofs_m = DATA_W'(103);
  endtask

  task automatic test_run_correction();
    logic [DATA_W-1:0] vin[3]  = '{DATA_W'(150), DATA_W'(50), DATA_W'(103)};
    logic [DATA_W-1:0] vexp[3] = '{DATA_W'(47),  DATA_W'(0),  DATA_W'(0)};
    logic [DATA_W-1:0] v;
    for (int i = 0; i < 3; i++) begin
      feed(vin[i]);
      n_cmp++; if (cal_a !== vexp[i]) begin n_err++; $display("FAIL run_fixed[%0d]: got %0d want %0d", i, cal_a, vexp[i]); end
    end
    for (int i = 0; i < 6; i++) begin
      v = (i % 2 == 0) ? DATA_W'($urandom()) : ofs_m + DATA_W'($urandom_range(0, 4)) - DATA_W'(2);
      feed(v);
      cal_m = sat_sub(v, ofs_m);
      n_cmp++; if (cal_a !== cal_m) begin n_err++; $display("FAIL run_rand[%0d]: lpf=%0d got %0d want %0d", i, v, cal_a, cal_m); end
    end
  endtask

  task automatic test_abort_restart();
    logic [DATA_W-1:0] s[4];
    logic [DATA_W-1:0] exp;
    bit ok;
    // Abort after 2 of 4 samples; strobes while busy must not move cal_o.
    done_a_cnt = 0;
    start_cal(0);
    step();
    feed($urandom()); feed($urandom());
    cal_abort = 1'b1;
    step();
    cal_abort = 1'b0;
    n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL abort_busy: got %b want 0", busy_a); end
    n_cmp++; if (ofs_a !== ofs_m) begin n_err++; $display("FAIL abort_ofs: got %0d want %0d", ofs_a, ofs_m); end
    n_cmp++; if (cal_a !== cal_m) begin n_err++; $display("FAIL abort_cal_hold: got %0d want %0d", cal_a, cal_m); end
    // Abort during the completion cycle discards the result.
    start_cal(0);
    step();
    for (int i = 0; i < 4; i++) feed($urandom());
    cal_abort = 1'b1;
    step();
    cal_abort = 1'b0;
    step();
    n_cmp++; if (done_a_cnt != 0) begin n_err++; $display("FAIL abort_done_cnt: got %0d want 0", done_a_cnt); end
    n_cmp++; if (ofs_a !== ofs_m) begin n_err++; $display("FAIL abort_done_ofs: got %0d want %0d", ofs_a, ofs_m); end
    // Start and abort together while idle: stay idle.
    cal_start = 1'b1; cal_abort = 1'b1;
    step();
    cal_start = 1'b0; cal_abort = 1'b0;
    n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL start_abort_idle: busy=%b want 0", busy_a); end
    // Start while busy is ignored: accumulation carries on.
    for (int i = 0; i < 4; i++) s[i] = $urandom();
    exp = mean4(s);
    start_cal(0);
    step();
    feed(s[0]); feed(s[1]);
    cal_start = 1'b1;
    step();
    cal_start = 1'b0;
    feed(s[2]); feed(s[3]);
    wait_idle_a(4, ok);
    n_cmp++; if (!ok) begin n_err++; $display("FAIL restart_timeout: busy=%b want 0", busy_a); end
    n_cmp++; if (done_a_cnt != 1) begin n_err++; $display("FAIL restart_done_cnt: got %0d want 1", done_a_cnt); end
    n_cmp++; if (ofs_a !== exp) begin n_err++; $display("FAIL restart_ofs: got %0d want %0d", ofs_a, exp); end
    ofs_m = exp;
  endtask

  task automatic test_random_cal();
    logic [DATA_W-1:0] s[4];
    logic [DATA_W-1:0] exp;
    logic [DATA_W-1:0] v;
    int st;
    bit ok;
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < 4; i++) s[i] = $urandom();
      exp = mean4(s);
      st  = $urandom_range(0, 5);
      done_a_cnt = 0;
      start_cal(st);
      repeat (st + 1) step();
      for (int i = 0; i < 4; i++) begin
        repeat ($urandom_range(0, 2)) step();
        feed(s[i]);
      end
      wait_idle_a(4, ok);
      step();
      n_cmp++; if (!ok || done_a_cnt != 1) begin n_err++; $display("FAIL rand_cal[%0d]: idle=%b done_cnt=%0d want 1/1", it, ok, done_a_cnt); end
      n_cmp++; if (ofs_a !== exp) begin n_err++; $display("FAIL rand_ofs[%0d]: got %0d want %0d", it, ofs_a, exp); end
      ofs_m = exp;
      v = ofs_m ^ DATA_W'($urandom_range(0, 255));
      feed(v);
      n_cmp++; if (cal_a !== sat_sub(v, ofs_m)) begin n_err++; $display("FAIL rand_run[%0d]: got %0d want %0d", it, cal_a, sat_sub(v, ofs_m)); end
    end
  endtask

  task automatic test_reset_mid_cal();
    start_cal(0);
    step();
    feed($urandom()); feed($urandom());
    rst_n = 1'b0;
    #1;
    n_cmp++; if (busy_a !== 1'b0) begin n_err++; $display("FAIL rmid_busy: got %b want 0", busy_a); end
    n_cmp++; if (ofs_a !== '0) begin n_err++; $display("FAIL rmid_ofs: got %0d want 0", ofs_a); end
    n_cmp++; if (cal_a !== '0) begin n_err++; $display("FAIL rmid_cal: got %0d want 0", cal_a); end
    d_shl = 4'd5;
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_cmp++; if (d_shl_a !== 4'd5) begin n_err++; $display("FAIL rmid_dshl: got %0d want 5", d_shl_a); end
    ofs_m = '0;
    cal_m = '0;
  endtask

  task automatic test_extremes();
    bit ok;
    done_a_cnt = 0;
    done_b_cnt = 0;
    start_cal(0);
    step();                                   // single settle cycle
    for (int i = 0; i < 16; i++) feed('1);
    ok = 1'b0;
    for (int i = 0; i < 4 && !ok; i++) begin
      step();
      ok = (busy_b === 1'b0);
    end
    step();
    n_cmp++; if (!ok || done_b_cnt != 1) begin n_err++; $display("FAIL ext_b_done: idle=%b done_cnt=%0d want 1/1", ok, done_b_cnt); end
    n_cmp++; if (ofs_b !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL ext_b_ofs: got %h want ffffffff", ofs_b); end
    n_cmp++; if (done_a_cnt != 1) begin n_err++; $display("FAIL ext_a_done_cnt: got %0d want 1", done_a_cnt); end
    n_cmp++; if (ofs_a !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL ext_a_ofs: got %h want ffffffff", ofs_a); end
    n_cmp++; if (cal_a !== '0) begin n_err++; $display("FAIL ext_a_cal: got %0d want 0", cal_a); end
  endtask

  initial begin
    rst_n     = 1'b0;
    cal_start = 1'b0;
    cal_abort = 1'b0;
    settle    = '0;
    d_shl     = '0;
    lpf       = '0;
    lpf_vld   = 1'b0;
    test_reset();
    test_settle_gating();
    test_basic_cal();
    test_run_correction();
    test_abort_restart();
    test_random_cal();
    test_reset_mid_cal();
    test_extremes();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_vol_cal_seq
